bcd_to_signed_bin: RTL

//  Sequential decimal-to-binary decoder: the inverse of the product path's binary-to-BCD stage.

---
 rtl/bcd_to_signed_bin.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bcd_to_signed_bin.sv
// Sequential packed-BCD (plus sign) to two's-complement converter.
// Reverse double-dabble: one right shift of {bcd, bin} per clock, 4*DIGITS shifts per conversion.
module bcd_to_signed_bin #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sign_in,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      value_out,
    output logic                  digit_err,
    output logic                  range_err
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(BW + 1);
    localparam int unsigned XW = BW + WIDTH;
    localparam logic [XW-1:0] POS_MAX = XW'((2 ** (WIDTH - 1)) - 1);
    localparam logic [XW-1:0] NEG_MAX = XW'(2 ** (WIDTH - 1));
    localparam logic [CW-1:0] LAST    = CW'(BW - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t           state, state_d;
    logic [BW-1:0]    bcd_reg, bcd_d;
    logic [BW-1:0]    bin_acc, bin_d;
    logic             sign_reg, sign_d;
    logic             err_pend, err_pend_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             busy_d, done_d, digit_err_d, range_err_d;
    logic [WIDTH-1:0] value_d;

    logic             in_bad;
    logic [2*BW-1:0]  sh;
    logic [XW-1:0]    mag_x;
    logic [WIDTH-1:0] mag_w, neg_w;

    // Any input nibble above 9 is not a decimal digit.
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
        end
    end

    // One shift step with the per-nibble correction applied after the shift.
    always_comb begin
        sh = {bcd_reg, bin_acc} >> 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sh[BW + 4*i + 3]) sh[BW + 4*i +: 4] = sh[BW + 4*i +: 4] - 4'd3;
        end
    end

    assign mag_x = XW'(bin_acc);
    assign mag_w = WIDTH'(bin_acc);
    assign neg_w = WIDTH'(0) - mag_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bcd_reg   <= '0;
            bin_acc   <= '0;
            sign_reg  <= 1'b0;
            err_pend  <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            value_out <= '0;
            digit_err <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state     <= state_d;
            bcd_reg   <= bcd_d;
            bin_acc   <= bin_d;
            sign_reg  <= sign_d;
            err_pend  <= err_pend_d;
            cnt       <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            value_out <= value_d;
            digit_err <= digit_err_d;
            range_err <= range_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        bcd_d       = bcd_reg;
        bin_d       = bin_acc;
        sign_d      = sign_reg;
        err_pend_d  = err_pend;
        cnt_d       = cnt;
        busy_d      = busy;
        done_d      = 1'b0;
        value_d     = value_out;
        digit_err_d = digit_err;
        range_err_d = range_err;

        case (state)
            IDLE: begin
                if (start) begin
                    bcd_d      = bcd_in;
                    sign_d     = sign_in;
                    bin_d      = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    err_pend_d = in_bad;
                    state_d    = in_bad ? FINISH : SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = sh;
                cnt_d          = cnt + CW'(1);
                if (cnt == LAST) state_d = FINISH;
            end
            FINISH: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
                digit_err_d = 1'b0;
                range_err_d = 1'b0;
                value_d     = '0;
                if (err_pend) begin
                    digit_err_d = 1'b1;
                end else if ((!sign_reg && mag_x > POS_MAX) || (sign_reg && mag_x > NEG_MAX)) begin
                    range_err_d = 1'b1;
                end else begin
                    value_d = sign_reg ? neg_w : mag_w;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
